// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg: shared FSM state type and width helpers for the sequential multiplier
package seq_mult_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  // Counter width able to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  // Product width for a given operand width.
  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/seq_mult_step.sv
// seq_mult_step: one add-shift step, adds mcand<<cnt into acc when the multiplier bit is set
module seq_mult_step #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic               bit_i,
  input  logic [CNT_W-1:0]   cnt_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [2*WIDTH-1:0] addend;

  // Partial product for the current multiplier bit, aligned to its weight
  always_comb begin
    addend = bit_i ? ({{WIDTH{1'b0}}, mcand_i} << cnt_i) : '0;
    acc_o  = acc_i + addend;
  end

endmodule

// File: rtl/seq_mult_hs.sv
// seq_mult_hs: shift-add sequential multiplier with valid/ready handshakes,
// per-operation signed mode and synchronous abort.
// Optional: define SEQ_MULT_EARLY_TERM_EN to finish as soon as the remaining
// multiplier bits are all zero.
module seq_mult_hs
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int PW    = prod_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    p_q, p_d;
  logic [PW-1:0]    step_acc;
  logic [PW-1:0]    result;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             in_fire, out_fire, last;

  seq_mult_step #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .bit_i   (mplier_q[0]),
    .cnt_i   (cnt_q),
    .acc_o   (step_acc)
  );

  // Final step detection: fixed WIDTH steps, or stop once no set multiplier bits remain
  always_comb begin
`ifdef SEQ_MULT_EARLY_TERM_EN
    last = (mplier_q >> 1) == '0;
`else
    last = cnt_q == CNT_W'(WIDTH - 1);
`endif
  end

  // Handshake, operand magnitudes and FSM next-state / datapath updates
  always_comb begin
    in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    out_valid = state_q == DONE;
    in_fire   = in_valid & in_ready;
    out_fire  = out_valid & out_ready;
    a_mag     = (is_signed & a[WIDTH-1]) ? -a : a;
    b_mag     = (is_signed & b[WIDTH-1]) ? -b : b;
    result    = neg_q ? -step_acc : step_acc;
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    p_d       = p_q;
    if (state_q == BUSY) begin
      acc_d    = step_acc;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (last) begin
        p_d     = result;
        state_d = DONE;
      end
    end
    if (out_fire) state_d = IDLE;
    if (in_fire) begin
      mcand_d  = a_mag;
      mplier_d = b_mag;
      neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc_d    = '0;
      cnt_d    = '0;
      state_d  = BUSY;
    end
    if (clr) begin
      state_d = IDLE;
      p_d     = p_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
    end
  end

  assign p = p_q;

endmodule
